// File: rtl/ksa_slice_sequencer.sv
// ksa_slice_sequencer
// Performs a WIDTH-bit addition by walking an external combinational
// SLICE-bit Kogge-Stone slice over the operands, least-significant slice
// first, with the inter-slice carry held in a register.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands; in_ready high, slice inputs held at zero
// RUN   | one slice per cycle through the external KSA, idx = slice index
// DONE  | result registered, out_valid high until the sink takes it
//
// Accept at edge k gives out_valid after edge k+NSL. The slice inputs are
// forced to zero outside RUN so the external adder does not toggle while
// the sequencer is idle or holding a result.

module ksa_slice_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [SLICE-1:0] slice_a,
  output logic [SLICE-1:0] slice_b,
  output logic             slice_cin,
  input  logic [SLICE-1:0] slice_sum,
  input  logic             slice_cout
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             out_valid_reg;

  logic accept;
  logic last_slice;
  logic result_taken;

  assign accept       = (state == IDLE) && in_valid;
  assign last_slice   = (state == RUN) && (idx == LAST_IDX);
  assign result_taken = (state == DONE) && out_ready;

  // State register; reset is synchronous and wins over any pending handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last_slice) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (result_taken) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operand capture, per-slice result/carry update and result handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx           <= '0;
      carry         <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      carry   <= cin;
      idx     <= '0;
      sum_reg <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NSL; i++) begin
        if (idx == IW'(i)) begin
          sum_reg[i*SLICE +: SLICE] <= slice_sum;
        end
      end
      carry <= slice_cout;
      if (last_slice) begin
        idx           <= '0;
        cout_reg      <= slice_cout;
        out_valid_reg <= 1'b1;
      end else begin
        idx <= idx + IW'(1);
      end
    end else if (result_taken) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Slice operand mux; inputs stay at zero unless a slice is being computed.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (state == RUN) begin
      slice_cin = carry;
      for (int i = 0; i < NSL; i++) begin
        if (idx == IW'(i)) begin
          slice_a = a_reg[i*SLICE +: SLICE];
          slice_b = b_reg[i*SLICE +: SLICE];
        end
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_ksa_slice_sequencer.sv
// Testbench for ksa_slice_sequencer: directed scenarios on a 32/8 instance
// plus randomized handshake traffic on 32/8, 16/4 and 8/8 instances, all
// checked against plain arithmetic a+b+cin.

module tb_ksa_slice_sequencer;

  int n_cmp = 0;
  int n_bad = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed instance (WIDTH=32, SLICE=8) ----------------
  logic        d_rst = 1'b0;
  logic        d_iv = 1'b0;
  logic        d_ir;
  logic [31:0] d_a = '0;
  logic [31:0] d_b = '0;
  logic        d_cin = 1'b0;
  logic        d_ov;
  logic        d_ordy = 1'b0;
  logic [31:0] d_sum;
  logic        d_cout;
  logic        d_busy;
  logic [7:0]  d_sa;
  logic [7:0]  d_sb;
  logic        d_scin;
  logic [7:0]  d_ss;
  logic        d_scout;

  assign {d_scout, d_ss} = {1'b0, d_sa} + {1'b0, d_sb} + {8'd0, d_scin};

  ksa_slice_sequencer #(.WIDTH(32), .SLICE(8)) u_dut (
    .clk        (clk),
    .rst_n      (d_rst),
    .in_valid   (d_iv),
    .in_ready   (d_ir),
    .a          (d_a),
    .b          (d_b),
    .cin        (d_cin),
    .out_valid  (d_ov),
    .out_ready  (d_ordy),
    .sum        (d_sum),
    .cout       (d_cout),
    .busy       (d_busy),
    .slice_a    (d_sa),
    .slice_b    (d_sb),
    .slice_cin  (d_scin),
    .slice_sum  (d_ss),
    .slice_cout (d_scout)
  );

  task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input logic cc,
                        output logic [3:0] cins, output logic [7:0] sa0,
                        output logic [7:0] sb0, output int lat);
    d_a   = aa;
    d_b   = bb;
    d_cin = cc;
    d_iv  = 1'b1;
    step();
    d_iv = 1'b0;
    lat  = 0;
    cins = '0;
    sa0  = d_sa;
    sb0  = d_sb;
    while (!d_ov && lat < 20) begin
      if (lat < 4) cins[lat[1:0]] = d_scin;
      step();
      lat++;
    end
  endtask

  task automatic take_result();
    d_ordy = 1'b1;
    step();
    d_ordy = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                          input logic cc);
    logic [3:0]  cins;
    logic [7:0]  sa0;
    logic [7:0]  sb0;
    int          lat;
    logic [32:0] exp;
    exp = {1'b0, aa} + {1'b0, bb} + {32'd0, cc};
    run_op(aa, bb, cc, cins, sa0, sb0, lat);
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_result"}, {d_cout, d_sum}, exp);
    chk({tag, "_done_in_ready"}, d_ir, 0);
    take_result();
    chk({tag, "_released"}, {d_ov, d_busy, d_ir}, 3'b001);
  endtask

  // ---------------- randomized instances ----------------
  localparam int NREQ = 1000;
  logic rst_n_g = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int W = (g == 0) ? 32 : (g == 1) ? 16 : 8;
    localparam int S = (g == 1) ? 4 : 8;

    logic         iv = 1'b0;
    logic         ir;
    logic [W-1:0] ra = '0;
    logic [W-1:0] rb = '0;
    logic         rc = 1'b0;
    logic         ov;
    logic         ordy = 1'b0;
    logic [W-1:0] rs;
    logic         co;
    logic         bsy;
    logic [S-1:0] sa;
    logic [S-1:0] sb;
    logic         scin;
    logic [S-1:0] ss;
    logic         scout;
    logic         done = 1'b0;
    logic [W:0]   exp_q[$];

    assign {scout, ss} = {1'b0, sa} + {1'b0, sb} + {{S{1'b0}}, scin};

    ksa_slice_sequencer #(.WIDTH(W), .SLICE(S)) u_rnd (
      .clk        (clk),
      .rst_n      (rst_n_g),
      .in_valid   (iv),
      .in_ready   (ir),
      .a          (ra),
      .b          (rb),
      .cin        (rc),
      .out_valid  (ov),
      .out_ready  (ordy),
      .sum        (rs),
      .cout       (co),
      .busy       (bsy),
      .slice_a    (sa),
      .slice_b    (sb),
      .slice_cin  (scin),
      .slice_sum  (ss),
      .slice_cout (scout)
    );

    // Drive at the falling edge, then record the handshakes that the next
    // rising edge will complete.
    initial begin
      int n_acc;
      int cyc;
      n_acc = 0;
      cyc   = 0;
      while (!rst_n_g) @(negedge clk);
      while ((n_acc < NREQ || exp_q.size() > 0) && cyc < 60000) begin
        @(negedge clk);
        iv   = (n_acc < NREQ) && ($urandom_range(0, 9) < 6);
        ra   = W'($urandom);
        rb   = W'($urandom);
        rc   = 1'($urandom);
        ordy = ($urandom_range(0, 9) < 6);
        #1;
        if (ov && ordy) begin
          if (exp_q.size() == 0) chk($sformatf("rnd%0d_extra_result", g), 1, 0);
          else chk($sformatf("rnd%0d_result", g), {co, rs}, exp_q.pop_front());
        end
        if (iv && ir) begin
          exp_q.push_back({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
          n_acc++;
        end
        cyc++;
      end
      chk($sformatf("rnd%0d_accepted", g), n_acc, NREQ);
      chk($sformatf("rnd%0d_drained", g), exp_q.size(), 0);
      iv   = 1'b0;
      ordy = 1'b0;
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0]  cins;
    logic [7:0]  sa0;
    logic [7:0]  sb0;
    int          lat;
    int          cyc;
    logic [31:0] hold_sum;

    repeat (3) step();
    rst_n_g = 1'b1;
    chk("rst_in_ready", d_ir, 1);
    chk("rst_out_valid", d_ov, 0);
    chk("rst_busy", d_busy, 0);
    chk("rst_sum", d_sum, 0);
    chk("rst_cout", d_cout, 0);
    chk("rst_slice_in", {d_sa, d_sb, d_scin}, 0);
    d_rst = 1'b1;
    step();

    d_ordy = 1'b1;
    repeat (3) step();
    d_ordy = 1'b0;
    chk("idle_hold", {d_ov, d_busy, d_ir}, 3'b001);

    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, cins, sa0, sb0, lat);
    chk("basic_latency", lat, 4);
    chk("basic_sum", d_sum, 32'h2345_6789);
    chk("basic_cout", d_cout, 0);
    chk("basic_slice_a0", sa0, 8'h78);
    chk("basic_slice_b0", sb0, 8'h11);
    chk("basic_slice_cin", cins, 4'b0000);
    chk("basic_done_busy", {d_busy, d_ir}, 2'b10);
    take_result();
    chk("basic_release", {d_ov, d_busy, d_ir}, 3'b001);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, cins, sa0, sb0, lat);
    chk("ripple_latency", lat, 4);
    chk("ripple_sum", d_sum, 32'h0);
    chk("ripple_cout", d_cout, 1);
    chk("ripple_slice_cin", cins, 4'b1110);
    take_result();

    op_check("cin_only_a", 32'hFFFF_FFFF, 32'h0, 1'b1);
    op_check("cin_only_b", 32'h7FFF_FFFF, 32'h0, 1'b1);
    op_check("mixed", 32'h8000_0001, 32'h8000_FFFF, 1'b1);

    // Backpressure: result must hold and no new operands may be accepted.
    run_op(32'hF102_0304, 32'h1020_3040, 1'b1, cins, sa0, sb0, lat);
    chk("bp_latency", lat, 4);
    hold_sum = 32'h0122_3345;
    for (int i = 0; i < 10; i++) begin
      d_iv = i[0];
      d_a  = $urandom;
      d_b  = $urandom;
      step();
      chk("bp_out_valid", d_ov, 1);
      chk("bp_sum", d_sum, hold_sum);
      chk("bp_cout", d_cout, 1);
      chk("bp_in_ready", d_ir, 0);
    end
    d_iv = 1'b0;
    take_result();
    chk("bp_release", {d_ov, d_busy, d_ir}, 3'b001);
    repeat (3) step();
    chk("bp_once", {d_ov, d_busy}, 2'b00);

    // Reset during the second RUN cycle discards the operation.
    d_a   = 32'h0F0F_0F0F;
    d_b   = 32'h1234_4321;
    d_cin = 1'b1;
    d_iv  = 1'b1;
    step();
    d_iv = 1'b0;
    step();
    d_rst = 1'b0;
    step();
    d_rst = 1'b1;
    chk("midrst_state", {d_ov, d_busy, d_ir}, 3'b001);
    chk("midrst_sum", d_sum, 0);
    chk("midrst_cout", d_cout, 0);
    cyc = 0;
    repeat (6) begin
      step();
      if (d_ov) cyc++;
    end
    chk("midrst_no_result", cyc, 0);
    op_check("after_rst", 32'hDEAD_BEEF, 32'h0123_4567, 1'b0);

    cyc = 0;
    while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) && cyc < 70000) begin
      step();
      cyc++;
    end
    chk("rnd_finished", {g_rnd[0].done, g_rnd[1].done, g_rnd[2].done}, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
